multdiv_unit: RTL and testbench

Parametrised, multi-cycle signed multiply/divide unit that sits beside the ALU in the execute stage of the pipelined processor. One operation runs at a time; the pipeline stalls while `busy` is high. A single-cycle `data_resultRDY` pulse marks completion, and the result plus an exception flag are held for the writeback path.

---
 rtl/multdiv_pkg.sv | 30 +++
 rtl/multdiv_div_step.sv | 29 ++
 rtl/multdiv_unit.sv | 170 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and helpers for the multiply/divide unit
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Two's-complement most-negative value for a w-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] most_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multdiv_div_step.sv
// rtl/multdiv_div_step.sv - one restoring-division iteration on unsigned magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic             w_shift_hi;
    logic [WIDTH-1:0] w_shift_lo;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_take;

    assign w_shift_hi = i_rem[WIDTH-1];
    assign w_shift_lo = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
    assign {w_borrow, w_diff} = {1'b0, w_shift_lo} - {1'b0, i_divisor};

    // A bit shifted out of the remainder means the shifted value already exceeds
    // any divisor, so the wrapped low-order difference is the true remainder.
    assign w_take = w_shift_hi | ~w_borrow;

    assign o_rem = w_take ? w_diff : w_shift_lo;
    assign o_quo = {i_quo[WIDTH-2:0], w_take};

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multi-cycle signed Booth multiply / restoring divide unit
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int               CW         = clog2(WIDTH);
    localparam logic [CW-1:0]    LAST       = CW'(WIDTH - 1);
    localparam logic [63:0]      MOST_NEG64 = most_neg(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG   = MOST_NEG64[WIDTH-1:0];

    state_t             r_state;
    state_t             w_state_next;
    op_t                r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH:0]   r_acc;
    logic               r_qm1;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_p;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_booth_acc;
    logic [WIDTH+1:0]   w_hi;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_signed;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Booth: the upper part is WIDTH+1 bits wide so that subtracting MIN never overflows.
    assign w_p     = r_acc[2*WIDTH:WIDTH];
    assign w_a_ext = {r_opa[WIDTH-1], r_opa};

    always_comb begin
        w_sum = w_p;
        case ({r_acc[0], r_qm1})
            2'b01:   w_sum = w_p + w_a_ext;
            2'b10:   w_sum = w_p - w_a_ext;
            default: w_sum = w_p;
        endcase
    end

    assign w_booth_acc = {w_sum[WIDTH], w_sum, r_acc[WIDTH-1:1]};

    // The product fits iff every bit from the result MSB upward is a sign copy.
    assign w_hi      = r_acc[2*WIDTH:WIDTH-1];
    assign w_mul_ovf = !((&w_hi) || !(|w_hi));

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    assign w_quo_signed = (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]) ? -r_quo : r_quo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                RUN:     w_state_next = (r_cnt == LAST) ? FIX : RUN;
                FIX:     w_state_next = DONE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op      <= OP_MULT;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_qm1     <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_exc     <= 1'b0;
        end else if (w_start) begin
            // A start in any state restarts cleanly; an op in flight is dropped.
            r_op      <= ctrl_MULT ? OP_MULT : OP_DIV;
            r_opa     <= data_operandA;
            r_opb     <= data_operandB;
            r_acc     <= {{(WIDTH + 1){1'b0}}, data_operandB};
            r_qm1     <= 1'b0;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == OP_MULT) begin
                        r_acc <= w_booth_acc;
                        r_qm1 <= r_acc[0];
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                    end
                end
                FIX: begin
                    if (r_op == OP_MULT) begin
                        r_result <= r_acc[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                    end else if (r_opb == '0) begin
                        r_result <= '0;
                        r_exc    <= 1'b1;
                    end else if ((r_opa == MOST_NEG) && (r_opb == '1)) begin
                        r_result <= MOST_NEG;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= w_quo_signed;
                        r_exc    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state == RUN) || (r_state == FIX);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit at WIDTH 32 and 8
module tb_multdiv_unit;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       nm;
    } exp_t;

    logic        clock;
    logic        rst32, m32, d32, exc32, rdy32, busy32;
    logic [31:0] a32, b32, res32;
    logic        rst8, m8, d8, exc8, rdy8, busy8;
    logic [7:0]  a8, b8, res8;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nb;
    exp_t q32[$];
    exp_t q8[$];

    multdiv_unit #(.WIDTH(32)) u32 (
        .clock          (clock),
        .reset          (rst32),
        .data_operandA  (a32),
        .data_operandB  (b32),
        .ctrl_MULT      (m32),
        .ctrl_DIV       (d32),
        .data_result    (res32),
        .data_exception (exc32),
        .data_resultRDY (rdy32),
        .busy           (busy32)
    );

    multdiv_unit #(.WIDTH(8)) u8 (
        .clock          (clock),
        .reset          (rst8),
        .data_operandA  (a8),
        .data_operandB  (b8),
        .ctrl_MULT      (m8),
        .ctrl_DIV       (d8),
        .data_result    (res8),
        .data_exception (exc8),
        .data_resultRDY (rdy8),
        .busy           (busy8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clock) begin : mon32
        exp_t e;
        if (rdy32) begin
            check("rdy32_expected", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check({e.nm, "_res"}, res32, e.res);
                check({e.nm, "_exc"}, {31'd0, exc32}, {31'd0, e.exc});
                check({e.nm, "_lat"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp_t e;
        if (rdy8) begin
            check("rdy8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check({e.nm, "_res"}, {24'd0, res8}, e.res);
                check({e.nm, "_exc"}, {31'd0, exc8}, {31'd0, e.exc});
                check({e.nm, "_lat"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic start(input bit w8, input bit m, input bit d, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] er,
                         input logic ee, input string nm);
        exp_t e;
        if (w8) begin
            m8 = m; d8 = d; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            m32 = m; d32 = d; a32 = a; b32 = b;
        end
        @(negedge clock);
        m32 = 1'b0; d32 = 1'b0; m8 = 1'b0; d8 = 1'b0;
        if (push) begin
            e.res = er;
            e.exc = ee;
            e.nm  = nm;
            e.cyc = cyc + (w8 ? 9 : 33);
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
        end
    endtask

    task automatic wait_done(input bit w8, input string nm, output int nbusy);
        bit got;
        got   = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 60; k++) begin
            if (w8 ? busy8 : busy32) nbusy++;
            if (w8 ? rdy8 : rdy32) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({nm, "_done"}, {31'd0, got}, 32'd1);
    endtask

    task automatic run_op(input bit w8, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee,
                          input string nm);
        int unused_busy;
        start(w8, m, d, a, b, 1'b1, er, ee, nm);
        wait_done(w8, nm, unused_busy);
        @(negedge clock);
    endtask

    initial begin
        rst32 = 1'b1; m32 = 1'b0; d32 = 1'b0; a32 = '0; b32 = '0;
        rst8  = 1'b1; m8  = 1'b0; d8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clock);
        check("rst_res",  res32, 32'd0);
        check("rst_exc",  {31'd0, exc32}, 32'd0);
        check("rst_rdy",  {31'd0, rdy32}, 32'd0);
        check("rst_busy", {31'd0, busy32}, 32'd0);
        check("rst_res8", {24'd0, res8}, 32'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;

        start(1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFD6, 1'b0, "mul_7_m6");
        check("mul_7_m6_busy_first", {31'd0, busy32}, 32'd1);
        wait_done(1'b0, "mul_7_m6", nb);
        check("mul_7_m6_busy_cycles", 32'(nb), 32'd33);
        @(negedge clock);

        run_op(1'b0, 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul_ovf");
        run_op(1'b0, 1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, "mul_min_1");
        run_op(1'b0, 1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        run_op(1'b0, 1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2");
        run_op(1'b0, 1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, "div_by_0");
        run_op(1'b0, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_m1");

        start(1'b0, 1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0, "mul_abort");
        repeat (9) @(negedge clock);
        start(1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "div_abort");
        wait_done(1'b0, "div_abort", nb);
        @(negedge clock);

        run_op(1'b0, 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, "tie_mult");

        start(1'b0, 1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, "mul_reset");
        repeat (4) @(negedge clock);
        rst32 = 1'b1;
        @(negedge clock);
        check("midrst_res",  res32, 32'd0);
        check("midrst_exc",  {31'd0, exc32}, 32'd0);
        check("midrst_rdy",  {31'd0, rdy32}, 32'd0);
        check("midrst_busy", {31'd0, busy32}, 32'd0);
        rst32 = 1'b0;
        repeat (40) @(negedge clock);
        run_op(1'b0, 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, "mul_2_2");

        start(1'b0, 1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0, "b2b_first");
        wait_done(1'b0, "b2b_first", nb);
        start(1'b0, 1'b0, 1'b1, 32'd50, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFF6, 1'b0, "b2b_second");
        wait_done(1'b0, "b2b_second", nb);
        @(negedge clock);

        run_op(1'b1, 1'b1, 1'b0, 32'd12, 32'd11, 32'h84, 1'b1, "w8_mul_12_11");
        start(1'b1, 1'b0, 1'b1, 32'h80, 32'h03, 1'b1, 32'hD6, 1'b0, "w8_div_m128_3");
        wait_done(1'b1, "w8_div_m128_3", nb);
        check("w8_busy_cycles", 32'(nb), 32'd9);

        repeat (3) @(negedge clock);
        check("q32_drained", 32'(q32.size()), 32'd0);
        check("q8_drained",  32'(q8.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
